acc_exec_unit: RTL and testbench
================================

Name: acc_exec_unit

Overview:
- Parametrised, registered successor to the combinational 16-bit accumulator ALU.
- Holds the accumulator (ACC) and a status-flag register internally, and accepts one opcode per handshake from the control unit.
- Keeps the existing opcode encodings and adds SUB/AND/OR/XOR, plus a multi-cycle shift-add MUL with a busy/ready handshake.
- Sits between the instruction decoder/controller and the memory data path; drives store data and branch decisions back to the controller.

Parameters:
- WIDTH, 16: datapath and accumulator width in bits; must be >= 4.
- CNT_W, $clog2(WIDTH)+1: width of the MUL iteration counter (derived; do not override).

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  opcode/operand present.
- op_ready  out  1  unit can accept an opcode this cycle.
- op  in  4  opcode.
- b_in  in  WIDTH  memory operand (B).
- acc_out  out  WIDTH  current ACC register.
- result_valid  out  1  one-cycle pulse: the ACC/flag update from the last accepted op is visible.
- st_valid  out  1  one-cycle pulse: store request (STA).
- st_data  out  WIDTH  data to store; valid with st_valid.
- br_taken  out  1  one-cycle pulse: the controller must load the PC.
- flags  out  4  {Z,N,C,V}.
- halted  out  1  sticky stop indication.

Behaviour:
- Reset: on any clock edge with rst=1, regardless of state (including mid-MUL or halted):
  - State goes to IDLE; ACC=0; flags=0.
  - result_valid, st_valid, br_taken, halted all =0; st_data=0; op_ready=1 in the following cycle.
- Accept: an op is accepted when op_valid && op_ready. op and b_in are sampled at that edge. With op_ready=0, op_valid is ignored; nothing is queued.
- States:
  - IDLE: op_ready=1. An accepted MUL goes to MBUSY; an accepted STP goes to HALT; every other op stays in IDLE.
  - MBUSY: op_ready=0. Runs exactly WIDTH iterations, then returns to IDLE.
  - HALT: op_ready=0 and halted=1 until rst.
- Opcodes (accepted at edge t; single-cycle results are visible in the cycle after t, with result_valid=1 in that cycle):
  - 0000 CLA: ACC=0.
  - 0001 COM: ACC=~ACC.
  - 0010 SHR: arithmetic right shift, ACC={ACC[MSB],ACC[MSB:1]}; C=ACC[0] before the shift.
  - 0011 CSL: rotate left by 1; C=ACC[MSB] before the rotate.
  - 0100 STP: enter HALT; no result_valid.
  - 0101 ADD: ACC=ACC+B mod 2^WIDTH; C=carry out; V=signed overflow.
  - 0110 STA: st_valid=1 and st_data=ACC in the next cycle; ACC and flags unchanged; result_valid=0.
  - 0111 LDA: ACC=B.
  - 1000 JMP: br_taken=1 in the next cycle; no ACC change.
  - 1001 BAN: br_taken=ACC[MSB], using ACC as it stood at the accept edge; no ACC change.
  - 1010 SUB: ACC=ACC-B, computed as ACC+~B+1; C=1 means no borrow; V=signed overflow.
  - 1011 AND, 1100 OR, 1101 XOR: bitwise with B.
  - 1110 MUL: unsigned ACC*B, 2*WIDTH-bit product, processed in MBUSY.
  - 1111 NOP: nothing changes; no pulses.
- Flag rules:
  - Z and N are recomputed from the new ACC on every ACC-writing op.
  - C is written by ADD, SUB, SHR, CSL and MUL; V is written by ADD and SUB; V is cleared by MUL. Otherwise C and V hold.
  - STA, JMP, BAN, STP and NOP leave all flags unchanged.
- MUL timing:
  - Operands are latched at the accept edge t.
  - One shift-add step per cycle for WIDTH cycles.
  - ACC is written with the low WIDTH bits of the product at edge t+WIDTH; result_valid=1 and op_ready=1 in the cycle after.
  - C=1 iff the high WIDTH bits of the product are nonzero.
  - acc_out keeps its old value throughout MBUSY.
- Pulse rules:
  - result_valid, st_valid and br_taken are single-cycle and mutually exclusive.
  - br_taken is never asserted with result_valid.
  - A back-to-back accept in the next cycle is allowed in IDLE; full throughput is 1 op/cycle for non-MUL ops.

Decomposition:
- Shared package alu_pkg holds:
  - OP_* 4-bit localparams: CLA=0 … NOP=15.
  - State encodings: ST_IDLE, ST_MBUSY, ST_HALT.
  - Flag bit indices: F_Z=3, F_N=2, F_C=1, F_V=0.
- One sub-module, seq_mul: shift-add multiplier.
  - Inputs: start, a, b; outputs: done, product[2*WIDTH-1:0].
  - Reset and clock are shared with the parent.
- All other operations are combinational next-ACC logic inside acc_exec_unit.

Test Plan (WIDTH=16):
1. rst=1 for 2 cycles mid-MUL (issue MUL, then reset after 5 cycles):
   - acc_out=0, flags=0, op_ready=1, no result_valid afterward.
2. LDA B=0x7FFF, then ADD B=0x0001:
   - acc_out=0x8000, flags {Z,N,C,V}=0101, result_valid pulses in both following cycles.
3. LDA 0x0005, then SUB 0x0005:
   - acc=0x0000, Z=1, C=1, V=0.
   - Then SHR with ACC=0x8001 (after LDA 0x8001): acc=0xC000, C=1.
4. LDA 0x0123, then MUL B=0x0100:
   - op_ready=0 for exactly 16 cycles.
   - acc=0x2300, C=1 (high half 0x0001), result_valid exactly once.
5. LDA 0x8000, BAN, STA, JMP issued back-to-back:
   - br_taken=1, then st_valid=1 with st_data=0x8000, then br_taken=1; ACC unchanged.
   - Repeat BAN with ACC=0x7FFF: br_taken=0.
6. STP, then op_valid held high with ADD:
   - halted=1, op_ready=0 indefinitely, ACC unchanged.
   - rst releases the unit to IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, state and flag-index definitions for the accumulator execution unit.
package alu_pkg;

    localparam logic [3:0] OP_CLA = 4'd0;
    localparam logic [3:0] OP_COM = 4'd1;
    localparam logic [3:0] OP_SHR = 4'd2;
    localparam logic [3:0] OP_CSL = 4'd3;
    localparam logic [3:0] OP_STP = 4'd4;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_STA = 4'd6;
    localparam logic [3:0] OP_LDA = 4'd7;
    localparam logic [3:0] OP_JMP = 4'd8;
    localparam logic [3:0] OP_BAN = 4'd9;
    localparam logic [3:0] OP_SUB = 4'd10;
    localparam logic [3:0] OP_AND = 4'd11;
    localparam logic [3:0] OP_OR  = 4'd12;
    localparam logic [3:0] OP_XOR = 4'd13;
    localparam logic [3:0] OP_MUL = 4'd14;
    localparam logic [3:0] OP_NOP = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MBUSY = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

endpackage

// File: rtl/acc_exec_unit_seq_mul.sv
// Shift-add unsigned multiplier: one step per cycle, WIDTH steps per product.
// done and product are combinational during the final step so the parent can capture on that edge.
module seq_mul #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // lo holds the unconsumed multiplier bits; the low product bits shift in behind them
    always_comb begin
        addend  = lo_q[0] ? mcand_q : '0;
        sum     = {1'b0, hi_q} + {1'b0, addend};
        hi_n    = sum[WIDTH:1];
        lo_n    = {sum[0], lo_q[WIDTH-1:1]};
        done    = busy_q && (cnt_q == CNT_W'(1));
        product = {hi_n, lo_n};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (start) begin
            busy_q  <= 1'b1;
            cnt_q   <= CNT_W'(WIDTH);
            mcand_q <= a;
            hi_q    <= '0;
            lo_q    <= b;
        end else if (busy_q) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/acc_exec_unit.sv
// Registered accumulator execution unit: ACC, {Z,N,C,V} flags, store/branch pulses, sequential MUL.
//   state    | meaning
//   ST_IDLE  | ready for one opcode per cycle
//   ST_MBUSY | multiplier running, opcodes refused
//   ST_HALT  | stopped after STP until reset
module acc_exec_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc_out,
    output logic             result_valid,
    output logic             st_valid,
    output logic [WIDTH-1:0] st_data,
    output logic             br_taken,
    output logic [3:0]       flags,
    output logic             halted
);
    import alu_pkg::*;

    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;
    logic             rv_q, rv_d;
    logic             stv_q, stv_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] std_q, std_d;
    logic             wr_acc;

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;

    assign op_ready  = (state_q == ST_IDLE);
    assign halted    = (state_q == ST_HALT);
    assign accept    = op_valid && op_ready;
    assign mul_start = accept && (op == OP_MUL);

    assign acc_out      = acc_q;
    assign flags        = flags_q;
    assign result_valid = rv_q;
    assign st_valid     = stv_q;
    assign st_data      = std_q;
    assign br_taken     = br_q;

    assign add_full = {1'b0, acc_q} + {1'b0, b_in};
    assign sub_full = {1'b0, acc_q} + {1'b0, ~b_in} + {{WIDTH{1'b0}}, 1'b1};

    seq_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_seq_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (acc_q),
        .b       (b_in),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        rv_d    = 1'b0;
        stv_d   = 1'b0;
        br_d    = 1'b0;
        std_d   = std_q;
        wr_acc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_CLA: begin acc_d = '0;     wr_acc = 1'b1; end
                        OP_COM: begin acc_d = ~acc_q; wr_acc = 1'b1; end
                        OP_SHR: begin
                            acc_d        = {acc_q[MSB], acc_q[MSB:1]};
                            flags_d[F_C] = acc_q[0];
                            wr_acc       = 1'b1;
                        end
                        OP_CSL: begin
                            acc_d        = {acc_q[MSB-1:0], acc_q[MSB]};
                            flags_d[F_C] = acc_q[MSB];
                            wr_acc       = 1'b1;
                        end
                        OP_STP: state_d = ST_HALT;
                        OP_ADD: begin
                            acc_d        = add_full[MSB:0];
                            flags_d[F_C] = add_full[WIDTH];
                            flags_d[F_V] = (acc_q[MSB] == b_in[MSB]) && (add_full[MSB] != acc_q[MSB]);
                            wr_acc       = 1'b1;
                        end
                        OP_STA: begin stv_d = 1'b1; std_d = acc_q; end
                        OP_LDA: begin acc_d = b_in; wr_acc = 1'b1; end
                        OP_JMP: br_d = 1'b1;
                        OP_BAN: br_d = acc_q[MSB];
                        OP_SUB: begin
                            acc_d        = sub_full[MSB:0];
                            flags_d[F_C] = sub_full[WIDTH];
                            flags_d[F_V] = (acc_q[MSB] != b_in[MSB]) && (sub_full[MSB] != acc_q[MSB]);
                            wr_acc       = 1'b1;
                        end
                        OP_AND: begin acc_d = acc_q & b_in; wr_acc = 1'b1; end
                        OP_OR:  begin acc_d = acc_q | b_in; wr_acc = 1'b1; end
                        OP_XOR: begin acc_d = acc_q ^ b_in; wr_acc = 1'b1; end
                        OP_MUL: state_d = ST_MBUSY;
                        default: ;
                    endcase
                end
            end
            ST_MBUSY: begin
                if (mul_done) begin
                    acc_d        = mul_product[WIDTH-1:0];
                    flags_d[F_C] = |mul_product[2*WIDTH-1:WIDTH];
                    flags_d[F_V] = 1'b0;
                    wr_acc       = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        if (wr_acc) begin
            flags_d[F_Z] = (acc_d == '0);
            flags_d[F_N] = acc_d[MSB];
            rv_d         = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            flags_q <= '0;
            rv_q    <= 1'b0;
            stv_q   <= 1'b0;
            br_q    <= 1'b0;
            std_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            rv_q    <= rv_d;
            stv_q   <= stv_d;
            br_q    <= br_d;
            std_q   <= std_d;
        end
    end

endmodule

// File: tb/tb_acc_exec_unit.sv
// Directed bench for acc_exec_unit at WIDTH=16 with hand-computed expectations.
module tb_acc_exec_unit;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] acc_out;
    logic             result_valid;
    logic             st_valid;
    logic [WIDTH-1:0] st_data;
    logic             br_taken;
    logic [3:0]       flags;
    logic             halted;

    int checks = 0;
    int errors = 0;

    acc_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op           (op),
        .b_in         (b_in),
        .acc_out      (acc_out),
        .result_valid (result_valid),
        .st_valid     (st_valid),
        .st_data      (st_data),
        .br_taken     (br_taken),
        .flags        (flags),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one opcode for a single edge; returns 1ns after that edge
    task automatic issue(input logic [3:0] o, input logic [WIDTH-1:0] b);
        op_valid = 1'b1;
        op       = o;
        b_in     = b;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic do_mul(input logic [WIDTH-1:0] b, input string tag,
                          input logic [WIDTH-1:0] exp_acc, input logic [3:0] exp_flags);
        logic [WIDTH-1:0] acc_before;
        int busy;
        int rv_seen;
        int acc_moved;
        acc_before = acc_out;
        busy = 0;
        rv_seen = 0;
        acc_moved = 0;
        issue(4'd14, b);
        // an LDA offered during MBUSY must be ignored, not queued
        op_valid = 1'b1;
        op       = 4'd7;
        b_in     = 16'hFFFF;
        while (!op_ready && busy < 40) begin
            if (result_valid) rv_seen++;
            if (acc_out !== acc_before) acc_moved++;
            busy++;
            tick();
        end
        op_valid = 1'b0;
        chk({tag, "_busy_cycles"}, busy, 16);
        chk({tag, "_rv_during_busy"}, rv_seen, 0);
        chk({tag, "_acc_held"}, acc_moved, 0);
        chk({tag, "_rv"}, result_valid, 1'b1);
        chk({tag, "_acc"}, acc_out, exp_acc);
        chk({tag, "_flags"}, flags, exp_flags);
        tick();
        chk({tag, "_rv_single"}, result_valid, 1'b0);
        chk({tag, "_acc_after"}, acc_out, exp_acc);
    endtask

    initial begin
        int rv_cnt;
        int ready_lo;
        rst      = 1'b1;
        op_valid = 1'b0;
        op       = 4'd15;
        b_in     = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_acc", acc_out, 16'h0000);
        chk("reset_flags", flags, 4'b0000);
        chk("reset_ready", op_ready, 1'b1);
        chk("reset_halted", halted, 1'b0);
        chk("reset_pulses", {result_valid, st_valid, br_taken}, 3'b000);

        // reset in the middle of a MUL
        issue(4'd7, 16'h0003);
        issue(4'd14, 16'h0005);
        repeat (5) tick();
        chk("mid_mul_busy", op_ready, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("mid_rst_acc", acc_out, 16'h0000);
        chk("mid_rst_flags", flags, 4'b0000);
        chk("mid_rst_ready", op_ready, 1'b1);
        rv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (result_valid) rv_cnt++;
            tick();
        end
        chk("mid_rst_no_rv", rv_cnt, 0);

        // ADD signed overflow
        issue(4'd7, 16'h7FFF);
        chk("lda_rv", result_valid, 1'b1);
        chk("lda_acc", acc_out, 16'h7FFF);
        issue(4'd5, 16'h0001);
        chk("add_rv", result_valid, 1'b1);
        chk("add_acc", acc_out, 16'h8000);
        chk("add_flags", flags, 4'b0101);

        // SUB to zero, then arithmetic shift
        issue(4'd7, 16'h0005);
        chk("lda5_flags", flags, 4'b0001);
        issue(4'd10, 16'h0005);
        chk("sub_acc", acc_out, 16'h0000);
        chk("sub_flags", flags, 4'b1010);
        issue(4'd7, 16'h8001);
        issue(4'd2, 16'h0000);
        chk("shr_acc", acc_out, 16'hC000);
        chk("shr_flags", flags, 4'b0110);

        // SUB with borrow and with overflow
        issue(4'd7, 16'h0000);
        issue(4'd10, 16'h0001);
        chk("sub_borrow_acc", acc_out, 16'hFFFF);
        chk("sub_borrow_flags", flags, 4'b0100);
        issue(4'd7, 16'h8000);
        issue(4'd10, 16'h0001);
        chk("sub_ovf_acc", acc_out, 16'h7FFF);
        chk("sub_ovf_flags", flags, 4'b0011);

        // multiplies
        issue(4'd7, 16'h0123);
        do_mul(16'h0100, "mul_a", 16'h2300, 4'b0010);
        issue(4'd7, 16'hFFFF);
        chk("ldaffff_flags", flags, 4'b0110);
        do_mul(16'hFFFF, "mul_b", 16'h0001, 4'b0010);
        issue(4'd7, 16'h0003);
        do_mul(16'h0005, "mul_c", 16'h000F, 4'b0000);

        // BAN / STA / JMP back-to-back
        issue(4'd7, 16'h8000);
        issue(4'd9, 16'h0000);
        chk("ban_br", br_taken, 1'b1);
        chk("ban_rv", result_valid, 1'b0);
        issue(4'd6, 16'h0000);
        chk("sta_pulses", {st_valid, br_taken, result_valid}, 3'b100);
        chk("sta_data", st_data, 16'h8000);
        issue(4'd8, 16'h0000);
        chk("jmp_pulses", {st_valid, br_taken, result_valid}, 3'b010);
        chk("jmp_acc", acc_out, 16'h8000);
        chk("jmp_flags", flags, 4'b0100);
        tick();
        chk("pulses_clear", {st_valid, br_taken, result_valid}, 3'b000);
        issue(4'd7, 16'h7FFF);
        issue(4'd9, 16'h0000);
        chk("ban_not_taken", {br_taken, result_valid}, 2'b00);

        // logic ops, rotate, clear, no-op
        issue(4'd7, 16'h0F0F);
        issue(4'd11, 16'h00FF);
        chk("and_acc", acc_out, 16'h000F);
        issue(4'd12, 16'hF000);
        chk("or_acc", acc_out, 16'hF00F);
        chk("or_flags", flags, 4'b0100);
        issue(4'd13, 16'hFFFF);
        chk("xor_acc", acc_out, 16'h0FF0);
        issue(4'd1, 16'h0000);
        chk("com_acc", acc_out, 16'hF00F);
        issue(4'd7, 16'h8001);
        issue(4'd3, 16'h0000);
        chk("csl_acc", acc_out, 16'h0003);
        chk("csl_flags", flags, 4'b0010);
        issue(4'd0, 16'h1234);
        chk("cla_acc", acc_out, 16'h0000);
        chk("cla_flags", flags, 4'b1010);
        issue(4'd15, 16'h1234);
        chk("nop_pulses", {st_valid, br_taken, result_valid}, 3'b000);
        chk("nop_state", {acc_out, flags}, {16'h0000, 4'b1010});

        // halt
        issue(4'd7, 16'h4321);
        issue(4'd4, 16'h0000);
        chk("stp_halted", halted, 1'b1);
        chk("stp_rv", result_valid, 1'b0);
        op_valid = 1'b1;
        op       = 4'd5;
        b_in     = 16'h0001;
        ready_lo = 0;
        for (int i = 0; i < 10; i++) begin
            if (!op_ready && halted) ready_lo++;
            tick();
        end
        op_valid = 1'b0;
        chk("halt_ready_low", ready_lo, 10);
        chk("halt_acc", acc_out, 16'h4321);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("halt_release", {halted, op_ready}, 2'b01);
        chk("halt_rst_acc", acc_out, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
